rr_stream_mux: RTL and testbench



---
 rtl/rr_stream_mux.sv | 185 ++++++++++++++++++
 tb/tb_rr_stream_mux.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel stream multiplexer with round-robin arbitration
// and a registered, skid-buffered output. It holds two beats: the output
// register and one skid register.
//
// Optional build macro: RR_STREAM_MUX_PACKET_LOCK_EN
//   When this macro is defined, a packet that starts on one channel keeps the
//   grant on that channel until its s_last beat is accepted.
//   When it is undefined, arbitration is per beat and s_last is only passed
//   through to m_last.
//
// Ports:
//   clock    : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   s_valid  : [NCH] per-channel valid
//   s_data   : [NCH*DSIZE] channel k occupies [k*DSIZE +: DSIZE]
//   s_last   : [NCH] per-channel end-of-packet
//   s_ready  : [NCH] per-channel ready, one-hot or zero
//   m_valid  : output beat valid
//   m_data   : [DSIZE] output data
//   m_last   : output end-of-packet
//   m_chan   : [CW] source channel of the current output beat
//   m_ready  : downstream ready
module rr_stream_mux #(
  parameter int DSIZE = 8,
  parameter int NCH   = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       s_valid,
  input  logic [NCH*DSIZE-1:0] s_data,
  input  logic [NCH-1:0]       s_last,
  output logic [NCH-1:0]       s_ready,
  output logic                 m_valid,
  output logic [DSIZE-1:0]     m_data,
  output logic                 m_last,
  output logic [CW-1:0]        m_chan,
  input  logic                 m_ready
);

  logic [CW-1:0]    r_ptr;
  logic             r_out_valid;
  logic [DSIZE-1:0] r_out_data;
  logic             r_out_last;
  logic [CW-1:0]    r_out_chan;
  logic             r_skid_valid;
  logic [DSIZE-1:0] r_skid_data;
  logic             r_skid_last;
  logic [CW-1:0]    r_skid_chan;

  logic [NCH-1:0]   w_req;
  logic [NCH-1:0]   w_req_hi;
  logic             w_gnt_any;
  logic [CW-1:0]    w_gnt_idx;
  logic [CW-1:0]    w_ptr_next;
  logic             w_in_room;
  logic             w_accept;
  logic             w_out_load;
  logic [DSIZE-1:0] w_sel_data;
  logic             w_sel_last;

`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
  logic             r_lock;
  logic [CW-1:0]    r_lock_ch;

  // While locked, only the lock owner may request; the owner is then the
  // only candidate, so the round-robin search below grants it directly.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_req[k] = s_valid[k] & (~r_lock | (r_lock_ch == CW'(k)));
    end
  end
`else
  assign w_req = s_valid;
`endif

  // Round-robin search: requests at or above ptr take priority, otherwise
  // the search wraps to the lowest requesting channel. Iterating downward
  // lets the lowest-index match in each group win.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      w_req_hi[k] = w_req[k] & (k >= int'(r_ptr));
    end
    if (|w_req_hi) begin
      w_gnt_any = 1'b1;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (w_req_hi[k]) w_gnt_idx = CW'(k);
      end
    end else if (|w_req) begin
      w_gnt_any = 1'b1;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (w_req[k]) w_gnt_idx = CW'(k);
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (w_gnt_idx == CW'(k)) begin
        w_sel_data = s_data[k*DSIZE +: DSIZE];
        w_sel_last = s_last[k];
      end
    end
  end

  // Room depends only on registered state, so m_ready never reaches s_ready.
  assign w_in_room  = ~r_skid_valid;
  assign w_accept   = w_gnt_any & w_in_room;
  assign w_out_load = ~r_out_valid | m_ready;
  assign w_ptr_next = (w_gnt_idx == CW'(NCH - 1)) ? '0 : w_gnt_idx + CW'(1);

  // rst_n also gates ready so no channel sees a grant while reset is held.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      s_ready[k] = w_accept & rst_n & (w_gnt_idx == CW'(k));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_chan   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_chan  <= '0;
    end else if (w_out_load) begin
      // The skid beat is older than any new beat, so it drains first.
      // A new beat cannot be accepted in that cycle because the skid is full.
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_last   <= r_skid_last;
        r_out_chan   <= r_skid_chan;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_sel_data;
        r_out_last   <= w_sel_last;
        r_out_chan   <= w_gnt_idx;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_sel_data;
      r_skid_last  <= w_sel_last;
      r_skid_chan  <= w_gnt_idx;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
    end
  end

`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
  // A non-last beat opens or continues a packet. A last beat closes it.
  // A single-beat packet therefore never sets the lock.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_accept) begin
      r_lock    <= ~w_sel_last;
      r_lock_ch <= w_gnt_idx;
    end
  end
`endif

  assign m_valid = r_out_valid;
  assign m_data  = r_out_data;
  assign m_last  = r_out_last;
  assign m_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  logic        clock;
  logic        rst_n;
  logic [3:0]  s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_last;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  m_chan;
  logic        m_ready;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [1:0] c;
  } beat_t;

  beat_t sb_q[$];
  beat_t sb_b;

  typedef struct {
    logic [3:0] sv;
    logic       mr;
    logic [3:0] rdy;
    logic       mv;
    logic [1:0] ch;
  } vec_t;

  vec_t tbl[11];
  int   exp5[5];

  rr_stream_mux #(.DSIZE(8), .NCH(4)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_chan  (m_chan),
    .m_ready (m_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: handshakes are sampled on the falling edge, which shows what
  // the next rising edge will transfer. Output beats are popped before new
  // input beats are pushed.
  always @(negedge clock) begin
    if (rst_n) begin
      chk("s_ready_onehot0", 32'($onehot0(s_ready)), 32'd1);
      if (m_valid && m_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_beat actual=%0h expected=none", m_data);
        end else begin
          sb_b = sb_q.pop_front();
          chk("sb_data", 32'(m_data), 32'(sb_b.d));
          chk("sb_last", 32'(m_last), 32'(sb_b.l));
          chk("sb_chan", 32'(m_chan), 32'(sb_b.c));
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (s_valid[k] && s_ready[k]) begin
          sb_q.push_back('{s_data[k*8 +: 8], s_last[k], 2'(k)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    logic [3:0] acc;

    checks   = 0;
    failures = 0;

    // The first entry starts at ptr=1 after case 1 and moves ptr to 0.
    // Entries 1..6 check the fairness rotation, 7..9 check the wrap and a
    // sparse request, and entry 10 checks that the output goes idle.
    tbl[0]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
    exp5 = '{0, 0, 0, 1, 1};
`else
    exp5 = '{0, 1, 0, 1, 0};
`endif

    // Case 1: reset with toggling inputs, then the first beat after release.
    rst_n   = 1'b0;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_valid = 4'($urandom);
      s_data  = 32'($urandom);
      s_last  = 4'($urandom);
      m_ready = 1'($urandom);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_m_chan", 32'(m_chan), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
    end
    tick();
    s_valid = 4'b0001;
    s_data  = 32'h000000A5;
    s_last  = 4'hF;
    m_ready = 1'b1;
    rst_n   = 1'b1;
    #1;
    chk("c1_s_ready", 32'(s_ready), 32'h1);
    tick();
    s_valid = '0;
    chk("c1_m_valid", 32'(m_valid), 32'd1);
    chk("c1_m_data", 32'(m_data), 32'hA5);
    chk("c1_m_chan", 32'(m_chan), 32'd0);
    tick();
    chk("c1_drain", 32'(m_valid), 32'd0);

    // Cases 2 and 4: table of fairness and wrap vectors.
    s_data = 32'hC3C2C1C0;
    s_last = 4'hF;
    for (int i = 0; i < 11; i++) begin
      s_valid = tbl[i].sv;
      m_ready = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
      if (tbl[i].mv) chk($sformatf("tbl%0d_m_chan", i), 32'(m_chan), 32'(tbl[i].ch));
    end

    // Case 3: backpressure fills the skid register, then drains in order.
    s_data  = 32'h33221100;
    m_ready = 1'b0;
    s_valid = 4'b0110;
    #1;
    chk("c3_grant_ch1", 32'(s_ready), 32'b0010);
    tick();
    s_valid = 4'b0100;
    chk("c3_m_valid", 32'(m_valid), 32'd1);
    chk("c3_m_data_11", 32'(m_data), 32'h11);
    chk("c3_m_chan_1", 32'(m_chan), 32'd1);
    #1;
    chk("c3_grant_ch2", 32'(s_ready), 32'b0100);
    tick();
    s_valid = 4'b1000;
    #1;
    chk("c3_full_ready", 32'(s_ready), 32'd0);
    chk("c3_hold_11", 32'(m_data), 32'h11);
    tick();
    chk("c3_stall_valid", 32'(m_valid), 32'd1);
    chk("c3_stall_11", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    #1;
    chk("c3_no_comb_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = '0;
    chk("c3_m_data_22", 32'(m_data), 32'h22);
    chk("c3_m_chan_2", 32'(m_chan), 32'd2);
    tick();
    chk("c3_drain", 32'(m_valid), 32'd0);

    // Case 5: ch0 sends a three-beat packet while ch1 is also valid.
    c0 = 0;
    c1 = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid[0]   = (c0 < 3);
      s_valid[1]   = (c1 < 2);
      s_valid[3:2] = 2'b00;
      s_data[7:0]  = 8'(8'h50 + c0);
      s_data[15:8] = 8'(8'h60 + c1);
      s_last[0]    = (c0 == 2);
      s_last[1]    = 1'b1;
      #1;
      acc = s_valid & s_ready;
      tick();
      chk($sformatf("c5_m_valid%0d", i), 32'(m_valid), 32'd1);
      chk($sformatf("c5_m_chan%0d", i), 32'(m_chan), 32'(exp5[i]));
      if (acc[0]) c0++;
      if (acc[1]) c1++;
    end
    s_valid = '0;
    s_last  = 4'hF;
    tick();
    chk("c5_drain", 32'(m_valid), 32'd0);
    chk("c5_beats", 32'(c0 * 10 + c1), 32'd32);

    // Case 6: asynchronous reset while the skid register is full.
    m_ready = 1'b0;
    s_data  = 32'h00000201;
    s_valid = 4'b0011;
    tick();
    tick();
    #1;
    chk("c6_full_ready", 32'(s_ready), 32'd0);
    chk("c6_full_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("c6_async_valid", 32'(m_valid), 32'd0);
    chk("c6_async_data", 32'(m_data), 32'd0);
    chk("c6_async_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 4'b1001;
    s_data  = 32'h88000077;
    m_ready = 1'b1;
    rst_n   = 1'b1;
    #1;
    chk("c6_ptr0_grant", 32'(s_ready), 32'b0001);
    tick();
    s_valid = '0;
    chk("c6_m_chan", 32'(m_chan), 32'd0);
    chk("c6_m_data", 32'(m_data), 32'h77);
    tick();
    chk("c6_drain", 32'(m_valid), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
